// File: rtl/matmul_result_streamer.sv
// matmul_result_streamer: after the CPU signals done, reads the M x N2 result
// matrix out of the byte-addressed data memory, reassembles each big-endian
// 32-bit word and streams it out with row/column tags over valid/ready.
module matmul_result_streamer #(
  parameter int M      = 2,
  parameter int N      = 4,
  parameter int N2     = 2,
  parameter int ADDR_W = 8,
  parameter int BASE   = M*N*4 + N*N2*4,
  localparam int ROW_W = (M  > 1) ? $clog2(M)  : 1,
  localparam int COL_W = (N2 > 1) ? $clog2(N2) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [ROW_W-1:0]  res_row,
  output logic [COL_W-1:0]  res_col,
  output logic              res_last,
  output logic              busy,
  output logic              complete
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_OUT,
    S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_done_q;
  logic               r_armed;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [1:0]         r_k;
  logic [31:0]        r_data;
  logic               r_complete;

  logic               w_start;
  logic               w_accept;
  logic               w_is_last;
  logic [ADDR_W-1:0]  w_addr;

  // A done level that was already high when reset released must not start a
  // readback; r_armed only sets once done has been seen low.
  assign w_start   = (r_state == S_IDLE) && done && !r_done_q && r_armed;
  assign w_accept  = (r_state == S_OUT) && res_ready;
  assign w_is_last = (r_row == ROW_W'(M-1)) && (r_col == COL_W'(N2-1));
  assign w_addr    = ADDR_W'(BASE + 4*(int'(r_row)*N2 + int'(r_col)) + int'(r_k));

  assign res_data  = r_data;
  assign res_row   = r_row;
  assign res_col   = r_col;
  assign complete  = r_complete;

  // State register.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_next    = r_state;
    mem_ren   = 1'b0;
    mem_addr  = '0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        mem_ren  = 1'b1;
        mem_addr = w_addr;
        if (r_k == 2'd3) w_next = S_LAST;
      end
      S_LAST: begin
        busy   = 1'b1;
        w_next = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_last  = w_is_last;
        if (w_accept) w_next = w_is_last ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        if (!done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: done edge tracking, element/byte counters, word assembly, completion flag.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_done_q   <= 1'b0;
      r_armed    <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_data     <= '0;
      r_complete <= 1'b0;
    end else begin
      r_done_q <= done;
      if (!done) r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_row      <= '0;
            r_col      <= '0;
            r_k        <= '0;
            r_complete <= 1'b0;
          end
        end
        S_FETCH: begin
          // Byte for address k-1 arrives one cycle after its request.
          if (r_k != 2'd0) r_data <= {r_data[23:0], mem_rdata};
          r_k <= r_k + 2'd1;
        end
        S_LAST: begin
          r_data <= {r_data[23:0], mem_rdata};
        end
        S_OUT: begin
          if (w_accept) begin
            if (w_is_last) begin
              r_complete <= 1'b1;
            end else begin
              r_k <= '0;
              if (r_col == COL_W'(N2-1)) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
